// File: rtl/gfx_pkg.sv
// Shared pixel types and helpers for the sprite mixing path.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package gfx_pkg;

  localparam int RGB_W   = 24;
  localparam int COORD_W = 16;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Split a packed {R,G,B} word into its channels.
  function automatic rgb_t rgb_unpack(input logic [RGB_W-1:0] v);
    rgb_t c;
    c.r = v[23:16];
    c.g = v[15:8];
    c.b = v[7:0];
    return c;
  endfunction

endpackage

// File: rtl/layer_priority_enc.sv
// Lowest-index-wins priority encoder over the layer hit vector.
// Latency: 0 cycles (purely combinational).
// Backpressure: none.
// Ports: i_hit (one bit per layer) -> o_vld (any hit), o_idx (winning layer).
module layer_priority_enc #(
  parameter int NUM_LAYERS = 4,
  parameter int IDX_W      = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic [NUM_LAYERS-1:0] i_hit,
  output logic                  o_vld,
  output logic [IDX_W-1:0]      o_idx
);

  // Scan from the top index downwards so the lowest set index is the last
  // one written and therefore wins.
  always_comb begin
    o_vld = 1'b0;
    o_idx = '0;
    for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
      if (i_hit[k]) begin
        o_vld = 1'b1;
        o_idx = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/sprite_layer_mixer.sv
// Merges sprite layers over a background by fixed priority and tracks per-frame player collisions.
// Latency: 2 cycles for RGB/de/x/y; collision results publish 2 cycles after the v_sync rising edge at the input.
// Backpressure: none; one pixel accepted and emitted every cycle.
// Ports: i_de/i_x/i_y/i_v_sync pixel timing, i_bg_rgb background, i_layer_rgb/i_layer_hit per-layer
//        colour and hit; o_red/o_green/o_blue/o_de/o_x/o_y aligned pixel out; o_frame_pulse,
//        o_collision, o_collision_mask, o_collision_count collision results of the previous frame.
module sprite_layer_mixer
  import gfx_pkg::*;
#(
  parameter int NUM_LAYERS   = 4,
  parameter int PLAYER_LAYER = 0,
  parameter int CNT_W        = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_de,
  input  logic [COORD_W-1:0]          i_x,
  input  logic [COORD_W-1:0]          i_y,
  input  logic                        i_v_sync,
  input  logic [RGB_W-1:0]            i_bg_rgb,
  input  logic [NUM_LAYERS*RGB_W-1:0] i_layer_rgb,
  input  logic [NUM_LAYERS-1:0]       i_layer_hit,
  output logic [7:0]                  o_red,
  output logic [7:0]                  o_green,
  output logic [7:0]                  o_blue,
  output logic                        o_de,
  output logic [COORD_W-1:0]          o_x,
  output logic [COORD_W-1:0]          o_y,
  output logic                        o_frame_pulse,
  output logic                        o_collision,
  output logic [NUM_LAYERS-1:0]       o_collision_mask,
  output logic [CNT_W-1:0]            o_collision_count
);

  localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam logic [NUM_LAYERS-1:0] PLAYER_BIT = NUM_LAYERS'(1) << PLAYER_LAYER;

  // Stage 1 registers
  logic                        r1_de;
  logic [COORD_W-1:0]          r1_x;
  logic [COORD_W-1:0]          r1_y;
  logic                        r1_vs;
  logic [RGB_W-1:0]            r1_bg;
  logic [NUM_LAYERS*RGB_W-1:0] r1_rgb;
  logic [NUM_LAYERS-1:0]       r1_hit;
  logic                        r1_sel_vld;
  logic [IDX_W-1:0]            r1_sel_idx;
  logic                        r_vs_d;

  // Stage 2 / output registers
  rgb_t                        r_rgb;
  logic                        r_de;
  logic [COORD_W-1:0]          r_x;
  logic [COORD_W-1:0]          r_y;
  logic                        r_pulse;
  logic                        r_coll;
  logic [NUM_LAYERS-1:0]       r_mask;
  logic [CNT_W-1:0]            r_count;
  logic [NUM_LAYERS-1:0]       r_acc;

  logic                        w_enc_vld;
  logic [IDX_W-1:0]            w_enc_idx;
  rgb_t                        w_mix;
  logic [NUM_LAYERS-1:0]       w_others;
  logic [NUM_LAYERS-1:0]       w_contrib;
  logic [NUM_LAYERS-1:0]       w_frame_mask;
  logic                        w_vs_rise;

  layer_priority_enc #(
    .NUM_LAYERS (NUM_LAYERS),
    .IDX_W      (IDX_W)
  ) u_enc (
    .i_hit (i_layer_hit),
    .o_vld (w_enc_vld),
    .o_idx (w_enc_idx)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r1_de      <= 1'b0;
      r1_x       <= '0;
      r1_y       <= '0;
      r1_vs      <= 1'b0;
      r1_bg      <= '0;
      r1_rgb     <= '0;
      r1_hit     <= '0;
      r1_sel_vld <= 1'b0;
      r1_sel_idx <= '0;
      r_vs_d     <= 1'b0;
    end else begin
      r1_de      <= i_de;
      r1_x       <= i_x;
      r1_y       <= i_y;
      r1_vs      <= i_v_sync;
      r1_bg      <= i_bg_rgb;
      r1_rgb     <= i_layer_rgb;
      r1_hit     <= i_layer_hit;
      r1_sel_vld <= w_enc_vld;
      r1_sel_idx <= w_enc_idx;
      r_vs_d     <= r1_vs;
    end
  end

  // Only the registered winner's slice is read, so colour bits of layers
  // that were not hit can never reach the outputs.
  always_comb begin
    w_mix = '0;
    if (r1_de) begin
      if (r1_sel_vld) begin
        w_mix = rgb_unpack(r1_rgb[r1_sel_idx*RGB_W +: RGB_W]);
      end else begin
        w_mix = rgb_unpack(r1_bg);
      end
    end
  end

  // A pixel collides only when the player and at least one other layer are
  // both opaque during active video; the player bit itself never enters the mask.
  assign w_others     = r1_hit & ~PLAYER_BIT;
  assign w_contrib    = (r1_de && r1_hit[PLAYER_LAYER] && (|w_others)) ? w_others : '0;
  assign w_frame_mask = r_acc | w_contrib;
  assign w_vs_rise    = r1_vs & ~r_vs_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rgb   <= '0;
      r_de    <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_pulse <= 1'b0;
      r_coll  <= 1'b0;
      r_mask  <= '0;
      r_count <= '0;
      r_acc   <= '0;
    end else begin
      r_rgb   <= w_mix;
      r_de    <= r1_de;
      r_x     <= r1_x;
      r_y     <= r1_y;
      r_pulse <= w_vs_rise;
      if (w_vs_rise) begin
        r_mask <= w_frame_mask;
        r_coll <= |w_frame_mask;
        if ((|w_frame_mask) && (r_count != '1)) begin
          r_count <= r_count + CNT_W'(1);
        end
        r_acc <= '0;
      end else begin
        r_acc <= w_frame_mask;
      end
    end
  end

  assign o_red             = r_rgb.r;
  assign o_green           = r_rgb.g;
  assign o_blue            = r_rgb.b;
  assign o_de              = r_de;
  assign o_x               = r_x;
  assign o_y               = r_y;
  assign o_frame_pulse     = r_pulse;
  assign o_collision       = r_coll;
  assign o_collision_mask  = r_mask;
  assign o_collision_count = r_count;

endmodule
